shift_arbiter: RTL and testbench
================================

# shift_arbiter

Shares one combinational barrel shifter between NUM_REQ independent requesters. Each requester issues shift operations over a valid/ready handshake. A round-robin arbiter accepts at most one operation per cycle and drives the shifter. The result is registered into a single-entry output slot, tagged with the requester index, and held under back-pressure until the consumer takes it.

## Interface
Parameters:
- DATA_LENGTH, 8, operand and result width in bits.
- NUM_REQ, 4, number of requesters; must be ≥ 2.
- Derived localparams: SAW = $clog2(DATA_LENGTH) (shift-amount width) and IDW = $clog2(NUM_REQ) (requester-index width).

Ports:
- clk, input, 1, single clock; all state updates on the rising edge.
- rst_n, input, 1, reset, synchronous, active-low.
- req_valid, input, NUM_REQ, bit i is high when requester i presents an operation.
- req_ready, output, NUM_REQ, bit i is high when requester i's operation is accepted this cycle; one-hot or zero.
- req_data, input, NUM_REQ*DATA_LENGTH, operand; slice i is [i*DATA_LENGTH +: DATA_LENGTH].
- req_right, input, NUM_REQ, 1 = shift right, 0 = shift left.
- req_arith, input, NUM_REQ, 1 = arithmetic; only meaningful together with right.
- req_sa, input, NUM_REQ*SAW, shift amount; slice i is [i*SAW +: SAW].
- rsp_valid, output, 1, output slot holds a result.
- rsp_ready, input, 1, consumer takes the result this cycle.
- rsp_data, output, DATA_LENGTH, shifted result.
- rsp_id, output, IDW, index of the requester that produced rsp_data.
- op_count, output, 16, number of operations accepted since reset; wraps 0xFFFF→0x0000.

## Operation
- Shift function, selected by {right, arith}:
  - 00: logical left (data << sa).
  - 10: logical right (data >> sa).
  - 11: arithmetic right (signed data >>> sa).
  - 01: pass data through unchanged.
- Slot state: the slot is free when !rsp_valid || rsp_ready.
- Arbitration:
  - Round-robin over req_valid, starting at pointer rr_ptr (IDW bits).
  - The first valid index at or after rr_ptr, searching modulo NUM_REQ, wins.
  - grant is one-hot or zero.
  - req_ready = grant & {NUM_REQ{slot_free}}.
  - req_ready is purely combinational from req_valid, rr_ptr, rsp_valid and rsp_ready. It does not depend on the payload.
- On accept (|req_ready):
  - rsp_data ← shifter result for the winner's payload.
  - rsp_id ← winner index.
  - rsp_valid ← 1.
  - rr_ptr ← (winner + 1) mod NUM_REQ.
  - op_count increments by 1.
- Slot free with no valid request: rsp_valid ← 0; rsp_data, rsp_id and rr_ptr hold.
- rsp_valid=1 and rsp_ready=0: rsp_valid, rsp_data and rsp_id hold; all req_ready are 0.
- Accept and drain in the same cycle are allowed: the slot is refilled with no bubble.
- Requester contract: hold the payload stable while req_valid && !req_ready. The block does not check this.
- Reset (rst_n=0 at a clock edge), regardless of any in-flight operation:
  - rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0, op_count=0.
  - The held result is discarded.
  - req_ready is 0 during the reset cycle.

## Timing
- Latency: an operation accepted in cycle N is visible on rsp_* in cycle N+1.
- Throughput: 1 operation/cycle when rsp_ready is held high.
- Fairness: a continuously asserting requester is granted within NUM_REQ accepts.
- No combinational path from req_* to rsp_*. The only input-to-output paths are req_valid/rsp_ready → req_ready.

## Structure
- Sub-module barrel_shifter:
  - One instance; combinational.
  - Ports: data_in (signed), right, arith, sa, data_out.
  - Parameter DATA_LENGTH is passed through.
  - Fed from the payload muxed by the one-hot grant.
- Shared package shift_pkg holds:
  - Mode encodings MODE_LEFT_LOGICAL=2'b00, MODE_RIGHT_LOGICAL=2'b10, MODE_RIGHT_ARITH=2'b11.
  - Function rr_pick(valid, ptr), returning the winner index and a found flag, reused by other arbiters.

## Test plan
Defaults for all scenarios: DATA_LENGTH=8, NUM_REQ=4.
- Single requester, all four modes on data 0x96:
  - req0 with right=1, arith=1, sa=2 → next cycle rsp_valid=1, rsp_data=0xE5, rsp_id=0.
  - {0,0}, sa=3 → 0xB0.
  - {1,0}, sa=4 → 0x09.
  - {0,1}, sa=5 → 0x96.
- All four requesters valid continuously, rsp_ready=1 → rsp_id sequence 0,1,2,3,0,1 with rsp_valid high every cycle; op_count advances by 1 per cycle.
- Wrap-around: req1 and req3 only.
  - Preload rr_ptr=3 by one accepted req2.
  - Result: grant order 3, then 1; rr_ptr returns to 2.
- Back-pressure:
  - rsp_ready=0 for 5 cycles after a result 0x5A id 2 → rsp_data/rsp_id stable, req_ready=0.
  - Raise rsp_ready → the pending request is accepted the same cycle and its result appears next cycle.
- Reset mid-operation: rsp_valid=1, rsp_ready=0, op_count=7, rst_n=0 for 1 cycle → all outputs 0; the first post-reset grant goes to the lowest valid index ≥ 0.
- op_count wrap: 65537 accepts → op_count=0x0001.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared shift-mode encodings and a reusable round-robin pick function.
package shift_pkg;

    localparam logic [1:0] MODE_LEFT_LOGICAL  = 2'b00;
    localparam logic [1:0] MODE_RIGHT_LOGICAL = 2'b10;
    localparam logic [1:0] MODE_RIGHT_ARITH   = 2'b11;

    localparam int RR_MAXW = 32;
    localparam int RR_IDXW = 5;

    typedef struct packed {
        logic               found;
        logic [RR_IDXW-1:0] idx;
    } rr_pick_t;

    // First set bit of valid at or after ptr, searching modulo n (n <= RR_MAXW).
    function automatic rr_pick_t rr_pick(input logic [RR_MAXW-1:0] valid,
                                         input logic [RR_IDXW-1:0] ptr,
                                         input int                 n);
        rr_pick_t r;
        int       j;
        r.found = 1'b0;
        r.idx   = '0;
        for (int k = 0; k < RR_MAXW; k++) begin
            if (k < n) begin
                j = int'(ptr) + k;
                if (j >= n) j = j - n;
                if (!r.found && valid[j]) begin
                    r.found = 1'b1;
                    r.idx   = RR_IDXW'(j);
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/barrel_shifter.sv
// Combinational shifter: logical left, logical right, arithmetic right or pass-through.
module barrel_shifter
    import shift_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    localparam int SAW = $clog2(DATA_LENGTH)
) (
    input  logic signed [DATA_LENGTH-1:0] data_in,
    input  logic                          right,
    input  logic                          arith,
    input  logic        [SAW-1:0]         sa,
    output logic        [DATA_LENGTH-1:0] data_out
);

    always_comb begin
        data_out = data_in;
        case ({right, arith})
            MODE_LEFT_LOGICAL:  data_out = data_in << sa;
            MODE_RIGHT_LOGICAL: data_out = $unsigned(data_in) >> sa;
            MODE_RIGHT_ARITH:   data_out = data_in >>> sa;
            default:            data_out = data_in;
        endcase
    end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one barrel shifter among NUM_REQ requesters,
// with a single registered, back-pressured output slot tagged by requester id.
module shift_arbiter
    import shift_pkg::*;
#(
    parameter int DATA_LENGTH = 8,
    parameter int NUM_REQ     = 4,
    localparam int SAW = $clog2(DATA_LENGTH),
    localparam int IDW = $clog2(NUM_REQ)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DATA_LENGTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_right,
    input  logic [NUM_REQ-1:0]             req_arith,
    input  logic [NUM_REQ*SAW-1:0]         req_sa,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [DATA_LENGTH-1:0]         rsp_data,
    output logic [IDW-1:0]                 rsp_id,
    output logic [15:0]                    op_count
);

    logic                   rsp_valid_q, rsp_valid_d;
    logic [DATA_LENGTH-1:0] rsp_data_q,  rsp_data_d;
    logic [IDW-1:0]         rsp_id_q,    rsp_id_d;
    logic [IDW-1:0]         rr_ptr_q,    rr_ptr_d;
    logic [15:0]            op_count_q,  op_count_d;

    rr_pick_t               pick;
    logic [NUM_REQ-1:0]     grant;
    logic [IDW-1:0]         win_id;
    logic                   slot_free;

    logic [DATA_LENGTH-1:0] sh_data, sh_out;
    logic                   sh_right, sh_arith;
    logic [SAW-1:0]         sh_sa;

    always_comb begin
        pick = rr_pick(RR_MAXW'(req_valid), RR_IDXW'(rr_ptr_q), NUM_REQ);
        for (int i = 0; i < NUM_REQ; i++)
            grant[i] = pick.found && (pick.idx == RR_IDXW'(i));
    end

    assign win_id    = IDW'(pick.idx);
    assign slot_free = !rsp_valid_q || rsp_ready;
    // Gated by rst_n so nothing is handed a ready during the reset cycle.
    assign req_ready = grant & {NUM_REQ{slot_free && rst_n}};

    // grant is one-hot, so OR-ing the gated slices is a cheap mux.
    always_comb begin
        sh_data  = '0;
        sh_right = 1'b0;
        sh_arith = 1'b0;
        sh_sa    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sh_data  = sh_data  | req_data[i*DATA_LENGTH +: DATA_LENGTH];
                sh_right = sh_right | req_right[i];
                sh_arith = sh_arith | req_arith[i];
                sh_sa    = sh_sa    | req_sa[i*SAW +: SAW];
            end
        end
    end

    barrel_shifter #(.DATA_LENGTH(DATA_LENGTH)) u_shifter (
        .data_in  (sh_data),
        .right    (sh_right),
        .arith    (sh_arith),
        .sa       (sh_sa),
        .data_out (sh_out)
    );

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rr_ptr_d    = rr_ptr_q;
        op_count_d  = op_count_q;
        if (|req_ready) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = sh_out;
            rsp_id_d    = win_id;
            rr_ptr_d    = (win_id == IDW'(NUM_REQ-1)) ? '0 : win_id + IDW'(1);
            op_count_d  = op_count_q + 16'd1;
        end else if (slot_free) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
            rr_ptr_q    <= '0;
            op_count_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rr_ptr_q    <= rr_ptr_d;
            op_count_q  <= op_count_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign op_count  = op_count_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Randomized and directed checks of shift_arbiter against a behavioural model.
module tb_shift_arbiter;

    localparam int DL  = 8;
    localparam int NR  = 4;
    localparam int SAW = 3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NR-1:0]  req_valid, req_ready, req_right, req_arith;
    logic [NR*DL-1:0]  req_data;
    logic [NR*SAW-1:0] req_sa;
    logic           rsp_valid, rsp_ready;
    logic [DL-1:0]  rsp_data;
    logic [1:0]     rsp_id;
    logic [15:0]    op_count;

    int tests_run    = 0;
    int tests_failed = 0;

    // model state
    logic        m_valid;
    logic [7:0]  m_data;
    int          m_id;
    int          m_ptr;
    logic [15:0] m_cnt;

    shift_arbiter #(.DATA_LENGTH(DL), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_data(req_data),
        .req_right(req_right), .req_arith(req_arith), .req_sa(req_sa),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .rsp_id(rsp_id), .op_count(op_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_shift(input logic [7:0] d, input logic r,
                                             input logic a, input int sa);
        int p, sv, q;
        p = 1 << sa;
        if (!r && !a) return 8'((int'(d) * p) % 256);
        if (r && !a)  return 8'(int'(d) / p);
        if (r && a) begin
            sv = d[7] ? int'(d) - 256 : int'(d);
            q  = (sv >= 0) ? sv / p : -((-sv + p - 1) / p);
            return 8'(q & 255);
        end
        return d;
    endfunction

    // Winner index the spec's rules pick this cycle, or -1 for no accept.
    function automatic int model_winner();
        int idx;
        if (!rst_n) return -1;
        if (m_valid && !rsp_ready) return -1;
        for (int k = 0; k < NR; k++) begin
            idx = (m_ptr + k) % NR;
            if (req_valid[idx]) return idx;
        end
        return -1;
    endfunction

    function automatic logic [NR-1:0] model_ready();
        int w;
        w = model_winner();
        return (w < 0) ? '0 : NR'(1 << w);
    endfunction

    function automatic void model_step();
        int w;
        if (!rst_n) begin
            m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0; m_cnt = '0;
            return;
        end
        w = model_winner();
        if (w >= 0) begin
            m_data  = ref_shift(req_data[w*DL +: DL], req_right[w], req_arith[w],
                                int'(req_sa[w*SAW +: SAW]));
            m_id    = w;
            m_valid = 1'b1;
            m_ptr   = (w + 1) % NR;
            m_cnt   = m_cnt + 16'd1;
        end else if (!m_valid || rsp_ready) begin
            m_valid = 1'b0;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_req(input int i, input logic [7:0] d, input logic r,
                           input logic a, input int sa);
        req_data[i*DL +: DL]   = d;
        req_right[i]           = r;
        req_arith[i]           = a;
        req_sa[i*SAW +: SAW]   = SAW'(sa);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '1; rsp_ready = 1'b0;
        req_data = '0; req_right = '0; req_arith = '0; req_sa = '0;
        tick();
        #1;
        tests_run++;
        if (req_ready !== '0) begin
            tests_failed++; $display("FAIL reset_ready got %b want 0", req_ready);
        end
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0 || op_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_state got v=%b d=%h id=%0d cnt=%h want zeros",
                     rsp_valid, rsp_data, rsp_id, op_count);
        end
        rst_n = 1'b1; req_valid = '0; rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_modes();
        logic [7:0] exp_d [4] = '{8'hE5, 8'hB0, 8'h09, 8'h96};
        logic       rr    [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic       aa    [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        int         ss    [4] = '{2, 3, 4, 5};
        for (int t = 0; t < 4; t++) begin
            set_req(0, 8'h96, rr[t], aa[t], ss[t]);
            req_valid = 4'b0001;
            #1;
            tests_run++;
            if (req_ready !== 4'b0001) begin
                tests_failed++; $display("FAIL mode%0d_ready got %b want 0001", t, req_ready);
            end
            tick();
            req_valid = '0;
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_data !== exp_d[t] || rsp_id !== 2'd0) begin
                tests_failed++;
                $display("FAIL mode%0d_result got v=%b d=%h id=%0d want v=1 d=%h id=0",
                         t, rsp_valid, rsp_data, rsp_id, exp_d[t]);
            end
        end
        tick();
    endtask

    task automatic test_rr_all();
        logic [15:0] c0;
        for (int i = 0; i < NR; i++) set_req(i, 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
        req_valid = '1; rsp_ready = 1'b1;
        c0 = op_count;
        for (int k = 1; k <= 6; k++) begin
            tick();
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'(m_id) || rsp_data !== m_data ||
                op_count !== c0 + 16'(k)) begin
                tests_failed++;
                $display("FAIL rr_all_%0d got v=%b id=%0d d=%h cnt=%h want v=1 id=%0d d=%h cnt=%h",
                         k, rsp_valid, rsp_id, rsp_data, op_count, m_id, m_data, c0 + 16'(k));
            end
        end
        req_valid = '0;
        tick();
    endtask

    task automatic test_wrap();
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1010;
        #1;
        tests_run++;
        if (req_ready !== 4'b1000) begin
            tests_failed++; $display("FAIL wrap_first got %b want 1000", req_ready);
        end
        tick();
        tests_run++;
        if (rsp_id !== 2'd3) begin
            tests_failed++; $display("FAIL wrap_id3 got %0d want 3", rsp_id);
        end
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++; $display("FAIL wrap_second got %b want 0010", req_ready);
        end
        tick();
        tests_run++;
        if (rsp_id !== 2'd1) begin
            tests_failed++; $display("FAIL wrap_id1 got %0d want 1", rsp_id);
        end
        req_valid = 4'b1111;
        #1;
        tests_run++;
        if (req_ready !== 4'b0100) begin
            tests_failed++; $display("FAIL wrap_ptr2 got %b want 0100", req_ready);
        end
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_back_pressure();
        logic [7:0] d1;
        set_req(2, 8'h5A, 1'b0, 1'b1, 0);
        req_valid = 4'b0100; rsp_ready = 1'b1;
        tick();
        d1 = 8'($urandom);
        set_req(1, d1, 1'b1, 1'b1, 3);
        req_valid = 4'b0010; rsp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            tests_run++;
            if (req_ready !== '0) begin
                tests_failed++; $display("FAIL bp_ready_%0d got %b want 0", k, req_ready);
            end
            tick();
            tests_run++;
            if (rsp_valid !== 1'b1 || rsp_data !== 8'h5A || rsp_id !== 2'd2) begin
                tests_failed++;
                $display("FAIL bp_hold_%0d got v=%b d=%h id=%0d want v=1 d=5a id=2",
                         k, rsp_valid, rsp_data, rsp_id);
            end
        end
        rsp_ready = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++; $display("FAIL bp_release_ready got %b want 0010", req_ready);
        end
        tick();
        req_valid = '0;
        tests_run++;
        if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== ref_shift(d1, 1'b1, 1'b1, 3)) begin
            tests_failed++;
            $display("FAIL bp_release_result got v=%b id=%0d d=%h want v=1 id=1 d=%h",
                     rsp_valid, rsp_id, rsp_data, ref_shift(d1, 1'b1, 1'b1, 3));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        req_valid = 4'b0001; rsp_ready = 1'b0;
        tick();
        req_valid = 4'b1010;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (req_ready !== '0) begin
            tests_failed++; $display("FAIL midrst_ready got %b want 0", req_ready);
        end
        tick();
        tests_run++;
        if (rsp_valid !== 1'b0 || rsp_data !== 8'h00 || rsp_id !== 2'd0 || op_count !== 16'h0) begin
            tests_failed++;
            $display("FAIL midrst_state got v=%b d=%h id=%0d cnt=%h want zeros",
                     rsp_valid, rsp_data, rsp_id, op_count);
        end
        rst_n = 1'b1;
        #1;
        tests_run++;
        if (req_ready !== 4'b0010) begin
            tests_failed++; $display("FAIL midrst_first_grant got %b want 0010", req_ready);
        end
        rsp_ready = 1'b1;
        tick();
        req_valid = '0;
        tick();
    endtask

    task automatic test_random();
        logic [NR-1:0] acc;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) begin
                if (!req_valid[i] || acc[i]) begin
                    req_valid[i] = 1'($urandom);
                    set_req(i, 8'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 7)));
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            #1;
            tests_run++;
            if (req_ready !== model_ready()) begin
                tests_failed++;
                $display("FAIL rand_ready_%0d got %b want %b", c, req_ready, model_ready());
            end
            acc = req_ready;
            tick();
            tests_run++;
            if (rsp_valid !== m_valid || (m_valid && (rsp_data !== m_data || rsp_id !== 2'(m_id))) ||
                op_count !== m_cnt) begin
                tests_failed++;
                $display("FAIL rand_rsp_%0d got v=%b d=%h id=%0d cnt=%h want v=%b d=%h id=%0d cnt=%h",
                         c, rsp_valid, rsp_data, rsp_id, op_count, m_valid, m_data, m_id, m_cnt);
            end
        end
        req_valid = '0; rsp_ready = 1'b1;
        tick();
    endtask

    task automatic test_count_wrap();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; req_valid = '1; rsp_ready = 1'b1;
        repeat (65537) tick();
        req_valid = '0;
        tests_run++;
        if (op_count !== 16'h0001 || op_count !== m_cnt) begin
            tests_failed++; $display("FAIL count_wrap got %h want 0001", op_count);
        end
    endtask

    initial begin
        test_reset();
        test_modes();
        test_rr_all();
        test_wrap();
        test_back_pressure();
        test_reset_mid();
        test_random();
        test_count_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
